// File: rtl/vidpll_mode_seq_pkg.sv
// Shared definitions for the video rPLL mode sequencer: state encoding,
// mode-table entry layout and a small sizing helper.
package vidpll_mode_seq_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        QUIESCE  = 3'd1,
        LOAD     = 3'd2,
        PLLRST   = 3'd3,
        WAITLOCK = 3'd4,
        STABLE   = 3'd5,
        RUN      = 3'd6,
        FAULT    = 3'd7
    } state_t;

    // Table entry = {idsel, fbdsel, odsel}
    localparam int ENTRY_W    = 18;
    localparam int CODE_W     = 6;
    localparam int ODSEL_LSB  = 0;
    localparam int FBDSEL_LSB = 6;
    localparam int IDSEL_LSB  = 12;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/vidpll_mode_seq_sync_2ff.sv
// Two-flop synchroniser for the asynchronous rPLL LOCK output.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vidpll_mode_seq.sv
// Mode sequencer for a dynamically reconfigured video rPLL: quiesce video,
// load divider codes, reset the PLL, wait for a stable lock, release video.
module vidpll_mode_seq
    import vidpll_mode_seq_pkg::*;
#(
    parameter int NUM_MODES    = 2,
    parameter int MODE_W       = 1,
    parameter logic [ENTRY_W*NUM_MODES-1:0] MODE_TABLE = {18'o777377, 18'o776677},
    parameter int QUIESCE_CYC  = 16,
    parameter int RST_CYC      = 32,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [MODE_W-1:0] mode_req,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [5:0]        pll_idsel,
    output logic [5:0]        pll_fbdsel,
    output logic [5:0]        pll_odsel,
    output logic [MODE_W-1:0] mode_act,
    output logic              video_reset_n,
    output logic              busy,
    output logic              fault,
    output logic [7:0]        relock_cnt
);

    localparam int CNT_MAX = max_of4(QUIESCE_CYC, RST_CYC, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] LD_QUIESCE = CNT_W'(QUIESCE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RST     = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAITLOCK cycle that first sees lock counts as stable cycle one.
    localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE - 2);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [RETRY_W-1:0]   retry;
    logic [MODE_W-1:0]    target;
    logic [MODE_W-1:0]    init_tgt;
    logic [ENTRY_W-1:0]   codes;
    logic                 lock_s;

    function automatic logic in_range(input logic [MODE_W-1:0] m);
        return int'(m) < NUM_MODES;
    endfunction

    function automatic logic [ENTRY_W-1:0] entry_of(input logic [MODE_W-1:0] m);
        return MODE_TABLE[ENTRY_W*int'(m) +: ENTRY_W];
    endfunction

    sync_2ff u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_lock),
        .q       (lock_s)
    );

    always_comb begin
        init_tgt = '0;
        if (in_range(mode_req)) init_tgt = mode_req;
    end

    assign pll_idsel  = codes[IDSEL_LSB  +: CODE_W];
    assign pll_fbdsel = codes[FBDSEL_LSB +: CODE_W];
    assign pll_odsel  = codes[ODSEL_LSB  +: CODE_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= INIT;
            cnt           <= '0;
            retry         <= '0;
            target        <= '0;
            codes         <= MODE_TABLE[ENTRY_W-1:0];
            pll_reset     <= 1'b1;
            video_reset_n <= 1'b0;
            mode_act      <= '0;
            busy          <= 1'b1;
            fault         <= 1'b0;
            relock_cnt    <= '0;
        end else begin
            case (state)
                INIT: begin
                    target <= init_tgt;
                    codes  <= entry_of(init_tgt);
                    cnt    <= '0;
                    state  <= LOAD;
                end
                QUIESCE: begin
                    // Codes change on LOAD entry so they are settled before the reset pulse.
                    if (cnt == '0) begin
                        codes <= entry_of(target);
                        state <= LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LOAD: begin
                    retry     <= '0;
                    pll_reset <= 1'b1;
                    cnt       <= LD_RST;
                    state     <= PLLRST;
                end
                PLLRST: begin
                    if (cnt == '0) begin
                        pll_reset <= 1'b0;
                        cnt       <= LD_TIMEOUT;
                        state     <= WAITLOCK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAITLOCK: begin
                    if (lock_s) begin
                        cnt   <= LD_STABLE;
                        state <= STABLE;
                    end else if (cnt == '0) begin
                        retry <= retry + 1'b1;
                        if (int'(retry) + 1 < MAX_RETRY) begin
                            pll_reset <= 1'b1;
                            cnt       <= LD_RST;
                            state     <= PLLRST;
                        end else begin
                            fault <= 1'b1;
                            busy  <= 1'b0;
                            cnt   <= '0;
                            state <= FAULT;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        cnt   <= LD_TIMEOUT;
                        state <= WAITLOCK;
                    end else if (cnt == '0) begin
                        mode_act      <= target;
                        video_reset_n <= 1'b1;
                        busy          <= 1'b0;
                        state         <= RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
                        video_reset_n <= 1'b0;
                        busy          <= 1'b1;
                        pll_reset     <= 1'b1;
                        retry         <= '0;
                        cnt           <= LD_RST;
                        state         <= PLLRST;
                    end else if (mode_req != mode_act && in_range(mode_req)) begin
                        target        <= mode_req;
                        video_reset_n <= 1'b0;
                        busy          <= 1'b1;
                        cnt           <= LD_QUIESCE;
                        state         <= QUIESCE;
                    end
                end
                FAULT: begin
                    if (mode_req != target && in_range(mode_req)) begin
                        target <= mode_req;
                        fault  <= 1'b0;
                        busy   <= 1'b1;
                        cnt    <= LD_QUIESCE;
                        state  <= QUIESCE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_vidpll_mode_seq.sv
// Randomised bench for vidpll_mode_seq: a lock model drives pll_lock and the
// expected timings are derived from the sequencing rules with plain arithmetic.
module tb_vidpll_mode_seq;

    localparam int NUM_MODES = 2;
    localparam int MODE_W    = 2;
    localparam int Q         = 3;
    localparam int R         = 4;
    localparam int T         = 64;
    localparam int LS        = 8;
    localparam int MR        = 2;
    localparam logic [35:0] TABLE = {18'o777377, 18'o776677};

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [MODE_W-1:0] mode_req;
    logic              pll_lock = 1'b0;
    logic              pll_reset;
    logic [5:0]        pll_idsel, pll_fbdsel, pll_odsel;
    logic [MODE_W-1:0] mode_act;
    logic              video_reset_n, busy, fault;
    logic [7:0]        relock_cnt;

    wire [17:0] obs_codes = {pll_idsel, pll_fbdsel, pll_odsel};

    always #5 clk = ~clk;

    vidpll_mode_seq #(
        .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .MODE_TABLE(TABLE),
        .QUIESCE_CYC(Q), .RST_CYC(R), .LOCK_TIMEOUT(T), .LOCK_STABLE(LS), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode_req(mode_req), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
        .pll_odsel(pll_odsel), .mode_act(mode_act), .video_reset_n(video_reset_n),
        .busy(busy), .fault(fault), .relock_cnt(relock_cnt)
    );

    int n_chk = 0, n_err = 0, cyc = 0;
    int lock_d = 20, glitch_gap = 0, lcnt = 0;
    bit lock_en = 1'b1;
    int t_prst_rise, t_prst_fall, t_vrn_rise, t_vrn_fall, t_codes, t_fault, t_lock_rise;
    int n_pulse = 0;
    int q_rise[$], q_fall[$];
    logic p_prst, p_vrn, p_fault;
    logic [17:0] p_codes;
    int exp_relock = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] tbl(input int m);
        logic [35:0] t;
        t = TABLE;
        return t[18*m +: 18];
    endfunction

    task automatic snap();
        p_prst = pll_reset; p_vrn = video_reset_n; p_fault = fault; p_codes = obs_codes;
    endtask

    // One clock: sample after the edge, log output transitions, advance the lock model.
    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (pll_reset && !p_prst) begin t_prst_rise = cyc; n_pulse++; q_rise.push_back(cyc); end
        if (!pll_reset && p_prst) begin t_prst_fall = cyc; q_fall.push_back(cyc); end
        if (video_reset_n && !p_vrn) t_vrn_rise = cyc;
        if (!video_reset_n && p_vrn) t_vrn_fall = cyc;
        if (fault && !p_fault) t_fault = cyc;
        if (obs_codes != p_codes) t_codes = cyc;
        snap();
        if (pll_reset) begin
            pll_lock = 1'b0;
            lcnt = 0;
        end else begin
            if (lock_en && lcnt == lock_d) begin pll_lock = 1'b1; t_lock_rise = cyc; end
            if (lock_en && glitch_gap > 0 && lcnt == lock_d + glitch_gap) pll_lock = 1'b0;
            if (lock_en && glitch_gap > 0 && lcnt == lock_d + glitch_gap + 1) begin
                pll_lock = 1'b1; t_lock_rise = cyc;
            end
            if (lcnt < 1000) lcnt++;
        end
    endtask

    task automatic wait_run(input string tag, input int budget);
        int n = 0;
        while (!(video_reset_n && !busy) && n < budget) begin step(); n++; end
        chk(tag, 32'(video_reset_n && !busy), 32'd1);
    endtask

    task automatic wait_fault(input string tag, input int budget);
        int n = 0;
        while (!fault && n < budget) begin step(); n++; end
        chk(tag, 32'(fault), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_prst"}, 32'(pll_reset), 32'd1);
        chk({tag, "_vrn"}, 32'(video_reset_n), 32'd0);
        chk({tag, "_codes"}, 32'(obs_codes), 32'(tbl(0)));
        chk({tag, "_act"}, 32'(mode_act), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_relock"}, 32'(relock_cnt), 32'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MODE_W-1:0] nm;
        logic [17:0] e;
        int n0;

        // Out-of-range request during reset: INIT must fall back to mode 0.
        mode_req = 2'd3;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        snap();
        @(negedge clk) reset_n = 1'b1;
        wait_run("up_run", 300);
        chk("up_lat", t_vrn_rise - t_lock_rise, 2 + LS);
        chk("up_codes", 32'(obs_codes), 32'(tbl(0)));
        chk("up_act", 32'(mode_act), 32'd0);

        n0 = n_pulse;
        repeat (20) step();
        chk("oor_busy", 32'(busy), 32'd0);
        chk("oor_vrn", 32'(video_reset_n), 32'd1);
        chk("oor_pulse", n_pulse, n0);

        // Mode changes with random lock delay.
        for (int k = 0; k < 4; k++) begin
            nm = mode_act ^ 2'd1;
            lock_d = $urandom_range(1, 50);
            mode_req = nm;
            step();
            chk("mc_vrn_fall", 32'(video_reset_n), 32'd0);
            chk("mc_busy", 32'(busy), 32'd1);
            wait_run("mc_run", 300);
            chk("mc_quiesce", t_codes - t_vrn_fall, Q);
            chk("mc_load", t_prst_rise - t_codes, 1);
            chk("mc_pulse", t_prst_fall - t_prst_rise, R);
            chk("mc_lat", t_vrn_rise - t_lock_rise, 2 + LS);
            chk("mc_act", 32'(mode_act), 32'(nm));
            e = tbl(int'(nm));
            chk("mc_fbd", 32'(pll_fbdsel), 32'(e[11:6]));
            chk("mc_od", 32'(pll_odsel), 32'(e[5:0]));
        end

        // Single-cycle lock glitch while counting stable cycles.
        for (int k = 0; k < 3; k++) begin
            nm = mode_act ^ 2'd1;
            lock_d = $urandom_range(1, 40);
            glitch_gap = $urandom_range(1, 6);
            mode_req = nm;
            step();
            wait_run("gl_run", 300);
            chk("gl_lat", t_vrn_rise - t_lock_rise, 2 + LS);
            chk("gl_act", 32'(mode_act), 32'(nm));
            glitch_gap = 0;
        end

        // Lock never arrives: retries then FAULT.
        lock_en = 1'b0;
        nm = mode_act ^ 2'd1;
        q_rise.delete(); q_fall.delete();
        n0 = n_pulse;
        mode_req = nm;
        wait_fault("ft_reach", 600);
        chk("ft_pulses", n_pulse - n0, MR);
        if (q_rise.size() >= 2 && q_fall.size() >= 2) begin
            chk("ft_w0", q_fall[0] - q_rise[0], R);
            chk("ft_w1", q_fall[1] - q_rise[1], R);
            chk("ft_to0", q_rise[1] - q_fall[0], T);
        end else begin
            chk("ft_edges", q_fall.size(), 2);
        end
        chk("ft_to1", t_fault - t_prst_fall, T);
        chk("ft_busy", 32'(busy), 32'd0);
        chk("ft_vrn", 32'(video_reset_n), 32'd0);
        chk("ft_prst", 32'(pll_reset), 32'd0);
        repeat (20) step();
        chk("ft_same", 32'(fault), 32'd1);
        mode_req = 2'd3;
        repeat (10) step();
        chk("ft_oor", 32'(fault), 32'd1);
        lock_en = 1'b1;
        lock_d = $urandom_range(1, 50);
        mode_req = nm ^ 2'd1;
        step();
        chk("ft_clear", 32'(fault), 32'd0);
        chk("ft_cbusy", 32'(busy), 32'd1);
        wait_run("ft_run", 300);
        chk("ft_act", 32'(mode_act), 32'(nm ^ 2'd1));
        chk("ft_codes", 32'(obs_codes), 32'(tbl(int'(nm ^ 2'd1))));

        // Unsolicited lock loss in RUN, until the counter saturates.
        nm = mode_act;
        e = obs_codes;
        for (int k = 0; k < 258; k++) begin
            lock_d = (k == 0) ? $urandom_range(1, 30) : 1;
            pll_lock = 1'b0;
            repeat (2) step();
            if (k == 0) chk("rl_sync", 32'(video_reset_n), 32'd1);
            step();
            if (exp_relock < 255) exp_relock++;
            chk("rl_cnt", 32'(relock_cnt), exp_relock);
            if (k == 0) begin
                chk("rl_vrn", 32'(video_reset_n), 32'd0);
                chk("rl_prst", 32'(pll_reset), 32'd1);
            end
            wait_run("rl_run", 300);
            if (k == 0) begin
                chk("rl_pulse", t_prst_fall - t_prst_rise, R);
                chk("rl_codes", 32'(obs_codes), 32'(e));
                chk("rl_act", 32'(mode_act), 32'(nm));
            end
        end
        chk("rl_sat", 32'(relock_cnt), 32'd255);

        // Asynchronous reset in the middle of the PLL reset pulse.
        mode_req = mode_act ^ 2'd1;
        begin
            int n = 0;
            step();
            while (!pll_reset && n < 50) begin step(); n++; end
            chk("mr_prst", 32'(pll_reset), 32'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("mr");
        nm = 2'($urandom_range(0, 1));
        mode_req = nm;
        lock_d = $urandom_range(1, 50);
        repeat (2) step();
        @(negedge clk) reset_n = 1'b1;
        wait_run("mr_run", 300);
        chk("mr_act", 32'(mode_act), 32'(nm));
        chk("mr_codes", 32'(obs_codes), 32'(tbl(int'(nm))));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
